cpu_mem_responder: RTL and testbench



---
 rtl/cpu_mem_responder_if.sv | 27 ++
 rtl/cpu_mem_responder.sv | 102 ++++++++++
 tb/tb_cpu_mem_responder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_responder_if.sv
// CPU fetch/data bus plus host program-loader handshake, shared by the responder and its users.
// The responder takes the slave side; the CPU/host side takes master.
interface cpu_mem_responder_if;
    logic [7:0]  PC;
    logic [15:0] InstrF;
    logic [7:0]  DataAdrM;
    logic [7:0]  WriteData;
    logic        MemWriteM;
    logic [7:0]  ReadDataM;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;
    logic        cpu_reset;

    modport slave (
        input  PC, DataAdrM, WriteData, MemWriteM, ld_start, ld_valid, ld_data,
        output InstrF, ReadDataM, ld_ready, ld_busy, ld_done, cpu_reset
    );

    modport master (
        output PC, DataAdrM, WriteData, MemWriteM, ld_start, ld_valid, ld_data,
        input  InstrF, ReadDataM, ld_ready, ld_busy, ld_done, cpu_reset
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Instruction and data memories for the 8-bit CPU, with a byte-serial loader that
// fills instruction memory from a host while holding the CPU in reset.
module cpu_mem_responder #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input logic                clk,
    input logic                reset,
    cpu_mem_responder_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StLen, StHi, StLo, StDone} ldState_e;

    logic [15:0] imem [IMEM_DEPTH];
    logic [7:0]  dmem [DMEM_DEPTH];

    ldState_e    state_q, state_d;
    logic [7:0]  wa_q, wa_d;
    logic [8:0]  rem_q, rem_d;
    logic [7:0]  hi_q, hi_d;

    logic        ldReady;
    logic        ldBusy;
    logic        accept;
    logic        imemWe;

    // Outputs are gated by reset so they read idle before the first reset edge too.
    assign ldReady = reset && (state_q == StLen || state_q == StHi || state_q == StLo);
    assign ldBusy  = reset && (state_q != StIdle);
    assign accept  = ldReady && bus.ld_valid;

    assign bus.ld_ready  = ldReady;
    assign bus.ld_busy   = ldBusy;
    assign bus.ld_done   = reset && (state_q == StDone);
    assign bus.cpu_reset = reset && !ldBusy;
    assign bus.InstrF    = ldBusy ? 16'h0000 : imem[bus.PC];
    assign bus.ReadDataM = dmem[bus.DataAdrM];

    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        imemWe  = 1'b0;
        if (bus.ld_start) begin
            // A start in any state restarts the stream; words already written stay.
            state_d = StLen;
            wa_d    = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StLen: begin
                    if (accept) begin
                        rem_d   = (bus.ld_data == 8'd0) ? 9'd256 : {1'b0, bus.ld_data};
                        state_d = StHi;
                    end
                end
                StHi: begin
                    if (accept) begin
                        hi_d    = bus.ld_data;
                        state_d = StLo;
                    end
                end
                StLo: begin
                    if (accept) begin
                        imemWe  = 1'b1;
                        wa_d    = wa_q + 8'd1;
                        rem_d   = rem_q - 9'd1;
                        state_d = (rem_q == 9'd1) ? StDone : StHi;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            wa_q    <= 8'd0;
            rem_q   <= 9'd0;
            hi_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            wa_q    <= wa_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
        end
    end

    // Arrays keep their contents across reset; stores are honoured in every loader state.
    always_ff @(posedge clk) begin
        if (imemWe) begin
            imem[wa_q] <= {hi_q, bus.ld_data};
        end
        if (bus.MemWriteM) begin
            dmem[bus.DataAdrM] <= bus.WriteData;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: reset, loads (plain, stalled, 256-word wrap),
// restart, abort and data-port stores during a load.
module tb_cpu_mem_responder;

    logic clk = 1'b0;
    logic reset;

    cpu_mem_responder_if bus ();

    cpu_mem_responder #(
        .IMEM_DEPTH(256),
        .DMEM_DEPTH(256)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int doneCnt  = 0;
    int lastDone = -1;
    int busyViol = 0;
    int lat;
    int doneBefore;
    logic [7:0] stream [600];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.ld_done === 1'b1) begin
            doneCnt++;
            lastDone = cyc;
        end
        if (bus.ld_busy === 1'b1 && (bus.InstrF !== 16'h0000 || bus.cpu_reset !== 1'b0)) begin
            busyViol++;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic readI(input logic [7:0] pc, input logic [15:0] exp, input string tag);
        bus.PC = pc;
        #1;
        check(tag, bus.InstrF, exp);
        bus.PC = 8'h00;
    endtask

    // Stream stream[0..len-1]; with stall, valid is dropped on every other cycle.
    task automatic runLoad(input int len, input bit stall, output int latency);
        int startCyc = cyc;
        int idx = 0;
        bit acc;
        lastDone = -1;
        bus.ld_start = 1'b1;
        bus.ld_valid = 1'b0;
        tick();
        bus.ld_start = 1'b0;
        while (idx < len && (cyc - startCyc) < 2000) begin
            if (stall && ((cyc - startCyc) % 2 == 1)) begin
                bus.ld_valid = 1'b0;
                acc = 1'b0;
            end else begin
                bus.ld_valid = 1'b1;
                bus.ld_data  = stream[idx];
                acc = bus.ld_ready;
            end
            tick();
            if (acc) idx++;
        end
        bus.ld_valid = 1'b0;
        latency = (lastDone < 0) ? -1 : lastDone - startCyc;
        for (int k = 0; k < 4 && bus.ld_busy === 1'b1; k++) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        bus.PC        = 8'h00;
        bus.DataAdrM  = 8'h00;
        bus.WriteData = 8'h00;
        bus.MemWriteM = 1'b0;
        bus.ld_start  = 1'b1;
        bus.ld_valid  = 1'b1;
        bus.ld_data   = 8'h55;

        // Reset held with start and valid asserted: loader must stay idle.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_busy", bus.ld_busy, 1'b0);
            check("rst_ready", bus.ld_ready, 1'b0);
            check("rst_cpu_reset", bus.cpu_reset, 1'b0);
            check("rst_done", bus.ld_done, 1'b0);
        end
        reset        = 1'b1;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        tick();
        check("post_rst_cpu_reset", bus.cpu_reset, 1'b1);
        check("post_rst_busy", bus.ld_busy, 1'b0);
        check("post_rst_ready", bus.ld_ready, 1'b0);

        // Three words so word 2 can later prove no stray writes.
        stream[0] = 8'h03;
        stream[1] = 8'h11; stream[2] = 8'h11;
        stream[3] = 8'h22; stream[4] = 8'h22;
        stream[5] = 8'h55; stream[6] = 8'h55;
        runLoad(7, 1'b0, lat);
        check("load3_latency", lat, 8);
        check("load3_done_count", doneCnt, 1);
        check("load3_cpu_reset", bus.cpu_reset, 1'b1);
        readI(8'h02, 16'h5555, "load3_word2");

        // Two-word load back to back.
        stream[0] = 8'h02;
        stream[1] = 8'h12; stream[2] = 8'h34;
        stream[3] = 8'hAB; stream[4] = 8'hCD;
        runLoad(5, 1'b0, lat);
        check("load2_latency", lat, 6);
        check("load2_done_count", doneCnt, 2);
        check("load2_busy_gating", busyViol, 0);
        readI(8'h00, 16'h1234, "load2_word0");
        readI(8'h01, 16'hABCD, "load2_word1");
        readI(8'h02, 16'h5555, "load2_word2");
        tick();

        // Same stream with alternate-cycle stalls: five stall cycles added.
        runLoad(5, 1'b1, lat);
        check("stall_latency", lat, 11);
        check("stall_done_count", doneCnt, 3);
        readI(8'h00, 16'h1234, "stall_word0");
        readI(8'h01, 16'hABCD, "stall_word1");
        readI(8'h02, 16'h5555, "stall_word2");
        tick();

        // Restart after the HI byte of word 1; word 0 gets rewritten.
        doneBefore   = doneCnt;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        sendByte(8'h02);
        sendByte(8'hAA);
        sendByte(8'hBB);
        sendByte(8'hCC);
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        check("restart_in_len_ready", bus.ld_ready, 1'b1);
        check("restart_busy", bus.ld_busy, 1'b1);
        sendByte(8'h01);
        sendByte(8'h77);
        sendByte(8'h88);
        check("restart_done", bus.ld_done, 1'b1);
        tick();
        check("restart_done_count", doneCnt, doneBefore + 1);
        check("restart_idle", bus.ld_busy, 1'b0);
        readI(8'h00, 16'h7788, "restart_word0");
        readI(8'h01, 16'hABCD, "restart_word1");
        tick();

        // Reset while in LO aborts without a done pulse or a write.
        doneBefore   = doneCnt;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        sendByte(8'h01);
        sendByte(8'h99);
        reset        = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h11;
        tick();
        check("abort_busy", bus.ld_busy, 1'b0);
        check("abort_done", bus.ld_done, 1'b0);
        reset        = 1'b1;
        bus.ld_valid = 1'b0;
        tick();
        tick();
        check("abort_done_count", doneCnt, doneBefore);
        check("abort_cpu_reset", bus.cpu_reset, 1'b1);
        readI(8'h00, 16'h7788, "abort_word0");
        tick();

        // Data store while idle, then a store in the middle of a load.
        bus.DataAdrM  = 8'h3C;
        bus.WriteData = 8'h11;
        bus.MemWriteM = 1'b1;
        tick();
        bus.MemWriteM = 1'b0;
        check("dmem_idle_store", bus.ReadDataM, 8'h11);
        doneBefore   = doneCnt;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        sendByte(8'h01);
        bus.MemWriteM = 1'b1;
        bus.WriteData = 8'h5A;
        bus.ld_valid  = 1'b1;
        bus.ld_data   = 8'h43;
        #1;
        check("dmem_same_cycle_old", bus.ReadDataM, 8'h11);
        tick();
        bus.MemWriteM = 1'b0;
        bus.ld_valid  = 1'b0;
        check("dmem_next_cycle_new", bus.ReadDataM, 8'h5A);
        sendByte(8'h21);
        check("dmem_load_done", bus.ld_done, 1'b1);
        tick();
        check("dmem_load_done_count", doneCnt, doneBefore + 1);
        readI(8'h00, 16'h4321, "dmem_load_word0");
        tick();

        // N=0 means 256 words; word address wraps without overwriting word 0.
        stream[0] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            stream[1 + 2 * i] = 8'(i);
            stream[2 + 2 * i] = ~8'(i);
        end
        doneBefore = doneCnt;
        runLoad(513, 1'b0, lat);
        check("wrap_latency", lat, 514);
        check("wrap_done_count", doneCnt, doneBefore + 1);
        check("wrap_busy_gating", busyViol, 0);
        readI(8'hFF, 16'hFF00, "wrap_word_ff");
        readI(8'h00, 16'h00FF, "wrap_word_00");
        readI(8'h80, 16'h807F, "wrap_word_80");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
